adc_scan_ctrl: RTL
==================

# adc_scan_ctrl

Multi-channel scan sequencer for the 3-bit flash ADC (`adc1x3`). It steps an analog input mux across a masked set of channels and waits a settling interval per channel. It then takes 2^AVG_LOG2 conversions, averages them, and presents one result per channel on a valid/ready port. It sits between the flash ADC datapath and any digital consumer, supporting single-scan and continuous modes.

## Interface
- NUM_CH, 4: number of mux channels (≥2); CH_W = $clog2(NUM_CH)
- SETTLE_CYC, 4: mux settling cycles per channel (≥1)
- AVG_LOG2, 2: log2 of samples averaged per channel (0..4)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  scan request, sampled in IDLE only
- ch_mask  in  NUM_CH  channels to scan; latched on accepted start
- continuous  in  1  repeat scans; latched on accepted start
- stop  in  1  level; ends continuous mode at the next scan boundary
- adc_code  in  3  flash ADC output code
- ch_sel  out  CH_W  analog mux select
- sample_en  out  1  high in cycles where adc_code is accumulated
- busy  out  1  high in any state other than IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_ch  out  CH_W  channel of current result
- res_data  out  3  averaged code
- done  out  1  one-cycle pulse at scan completion

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, OUTPUT.
- IDLE → SETTLE on start=1 with ch_mask≠0.
  - Latch mask and continuous.
  - ch_sel = lowest set mask bit.
  - Clear settle counter and accumulator.
- start with ch_mask=0 is ignored. start while busy is ignored.
- SETTLE: lasts exactly SETTLE_CYC cycles, then → SAMPLE.
- SAMPLE: lasts exactly 2^AVG_LOG2 cycles with sample_en=1.
  - Each cycle, acc += adc_code; acc width is 3+AVG_LOG2 bits and never overflows.
  - On the last sample, res_data is registered as (acc_final >> AVG_LOG2). This is truncation with no rounding, and the result is ≤7.
  - Then → OUTPUT.
- OUTPUT: res_valid=1; res_ch and res_data are held stable.
  - The state holds until res_ready=1. There is no drop or overrun; the scan stalls.
  - On handshake, go to the next higher set bit of the latched mask → SETTLE with the new ch_sel.
- After the last set bit is handshaken:
  - If latched continuous=1 and stop=0, wrap to the lowest set bit → SETTLE. done is not pulsed.
  - Otherwise, pulse done for one cycle and go to IDLE.
- ch_sel changes only on entry to SETTLE. It is held through SAMPLE and OUTPUT.

## Timing
- Reset value of every output is 0: ch_sel, sample_en, busy, res_valid, res_ch, res_data, done.
- Reset is asynchronous and may arrive in any state. It forces IDLE, clears the latched mask, counters and accumulator, and drops res_valid with no handshake.
- start accepted at edge 0:
  - busy=1 and SETTLE from cycle 1.
  - sample_en in cycles SETTLE_CYC+1 .. SETTLE_CYC+2^AVG_LOG2.
  - res_valid from cycle SETTLE_CYC+2^AVG_LOG2+1.
- Per-channel period with res_ready tied high: SETTLE_CYC + 2^AVG_LOG2 + 1 cycles.
- Final handshake at edge T: done=1 and busy=0 in cycle T+1. A new start is accepted from cycle T+1.
- stop is sampled only at the final-channel handshake. Asserting stop mid-scan completes the current scan.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package adc_pkg holds:
  - ADC_BITS=3 and ADC_LEVELS=8, shared with the flash ADC blocks
  - the scan_state_t enum {IDLE, SETTLE, SAMPLE, OUTPUT}
- Sub-module adc_next_ch: a combinational priority finder. Given a mask and the current channel, it returns the next higher set bit plus a wrap flag. Its lowest-set-bit mode is used for the first channel.
- Counters: settle (CH-independent, $clog2(SETTLE_CYC+1) bits), sample (AVG_LOG2+1 bits), and accumulator.

## Test plan
(NUM_CH=4, SETTLE_CYC=4, AVG_LOG2=2, res_ready=1 unless stated)
- Single scan: ch_mask=4'b0101, adc_code=5 constant, start at edge 0.
  - res_valid cycle 9 with res_ch=0, res_data=5.
  - res_valid cycle 18 with res_ch=2, res_data=5.
  - done=1 and busy=0 at cycle 19.
- Averaging: ch_mask=4'b0001, adc_code=1,2,3,4 across the four sample_en cycles → res_data=2 (10>>2). adc_code=7 throughout → res_data=7.
- Backpressure: res_ready=0 for 5 cycles during OUTPUT.
  - res_valid, res_ch and res_data are held; ch_sel is stable; sample_en=0.
  - The next channel's SETTLE starts the cycle after res_ready=1.
- Continuous: ch_mask=4'b1000, continuous=1.
  - Results for ch 3 every 9 cycles with no done.
  - stop raised mid-SAMPLE → current result delivered, done pulses, then IDLE.
- Illegal and racing requests:
  - start with ch_mask=0 → busy stays 0.
  - start pulsed while busy → ignored, and the scan order is unchanged.
- Reset mid-SAMPLE: rst_n low asynchronously → all outputs 0 immediately. After release, a fresh start behaves exactly as the single-scan test.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the flash ADC blocks and the scan sequencer.
package adc_pkg;

    localparam int unsigned ADC_BITS   = 3;
    localparam int unsigned ADC_LEVELS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        OUTPUT
    } scan_state_t;

endpackage

// File: rtl/adc_next_ch.sv
// Combinational priority finder over a channel mask: next higher set bit
// after cur (with wrap to the lowest set bit), or the lowest set bit outright.
module adc_next_ch #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              find_lowest,
    output logic [CH_W-1:0]   nxt,
    output logic              wrap
);

    logic [CH_W-1:0] lowest;
    logic [CH_W-1:0] higher;
    logic            found;

    // Descending scan so the last hit written is the smallest qualifying index.
    always_comb begin
        lowest = '0;
        higher = '0;
        found  = 1'b0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (mask[i-1]) begin
                lowest = CH_W'(i - 1);
                if ((i - 1) > 32'(cur)) begin
                    higher = CH_W'(i - 1);
                    found  = 1'b1;
                end
            end
        end
        wrap = !find_lowest && !found;
        nxt  = (find_lowest || !found) ? lowest : higher;
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel scan sequencer: settle, average 2^AVG_LOG2 samples, and
// hand one result per masked channel to a valid/ready consumer.
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 4,
    parameter  int unsigned SETTLE_CYC = 4,
    parameter  int unsigned AVG_LOG2   = 2,
    localparam int unsigned CH_W       = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic                continuous,
    input  logic                stop,
    input  logic [ADC_BITS-1:0] adc_code,
    output logic [CH_W-1:0]     ch_sel,
    output logic                sample_en,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CH_W-1:0]     res_ch,
    output logic [ADC_BITS-1:0] res_data,
    output logic                done
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned SMP_W = AVG_LOG2 + 1;
    localparam int unsigned ACC_W = ADC_BITS + AVG_LOG2;
    localparam int unsigned NSAMP = 1 << AVG_LOG2;

    scan_state_t         state_q,  state_d;
    logic [NUM_CH-1:0]   mask_q,   mask_d;
    logic                cont_q,   cont_d;
    logic [CH_W-1:0]     ch_q,     ch_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [SMP_W-1:0]    samp_q,   samp_d;
    logic [ACC_W-1:0]    acc_q,    acc_d;
    logic [ADC_BITS-1:0] data_q,   data_d;
    logic                done_q,   done_d;

    logic [ACC_W-1:0]    acc_sum;
    logic [NUM_CH-1:0]   find_mask;
    logic                find_lowest;
    logic [CH_W-1:0]     next_ch;
    logic                next_wrap;

    // In IDLE the finder looks at the live mask so the first channel is ready at start.
    assign find_lowest = (state_q == IDLE);
    assign find_mask   = find_lowest ? ch_mask : mask_q;
    assign acc_sum     = acc_q + ACC_W'(adc_code);

    adc_next_ch #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_next_ch (
        .mask        (find_mask),
        .cur         (ch_q),
        .find_lowest (find_lowest),
        .nxt         (next_ch),
        .wrap        (next_wrap)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        cont_d   = cont_q;
        ch_d     = ch_q;
        settle_d = settle_q;
        samp_d   = samp_q;
        acc_d    = acc_q;
        data_d   = data_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && (ch_mask != '0)) begin
                    mask_d   = ch_mask;
                    cont_d   = continuous;
                    ch_d     = next_ch;
                    settle_d = '0;
                    acc_d    = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                    samp_d  = '0;
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                acc_d  = acc_sum;
                samp_d = samp_q + 1'b1;
                if (samp_q == SMP_W'(NSAMP - 1)) begin
                    data_d  = ADC_BITS'(acc_sum >> AVG_LOG2);
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (res_ready) begin
                    if (!next_wrap || (cont_q && !stop)) begin
                        ch_d     = next_ch;
                        settle_d = '0;
                        acc_d    = '0;
                        state_d  = SETTLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            ch_q     <= '0;
            settle_q <= '0;
            samp_q   <= '0;
            acc_q    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            ch_q     <= ch_d;
            settle_q <= settle_d;
            samp_q   <= samp_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign ch_sel    = ch_q;
    assign res_ch    = ch_q;
    assign res_data  = data_q;
    assign sample_en = (state_q == SAMPLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == OUTPUT);
    assign done      = done_q;

endmodule
